// File: rtl/knapsack_search_if.sv
// Item-table configuration, search start and result signals of knapsack_search.
// i_ signals flow into the search block, o_ signals flow out of it.
interface knapsack_search_if #(
    parameter int N_ITEMS = 5,
    parameter int VW      = 16
);
    localparam int IW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    logic               i_cfg_we;
    logic [IW-1:0]      i_cfg_idx;
    logic [VW-1:0]      i_cfg_value;
    logic [VW-1:0]      i_cfg_weight;
    logic [VW-1:0]      i_min_value;
    logic [VW-1:0]      i_max_weight;
    logic               i_start;
    logic               o_busy;
    logic               o_done;
    logic               o_found;
    logic [N_ITEMS-1:0] o_best_sel;
    logic [VW+2:0]      o_best_value;
    logic [VW+2:0]      o_best_weight;
    logic [N_ITEMS-1:0] o_cand_sel;

    modport master (
        output i_cfg_we, i_cfg_idx, i_cfg_value, i_cfg_weight,
               i_min_value, i_max_weight, i_start,
        input  o_busy, o_done, o_found, o_best_sel, o_best_value,
               o_best_weight, o_cand_sel
    );

    modport slave (
        input  i_cfg_we, i_cfg_idx, i_cfg_value, i_cfg_weight,
               i_min_value, i_max_weight, i_start,
        output o_busy, o_done, o_found, o_best_sel, o_best_value,
               o_best_weight, o_cand_sel
    );
endinterface

// File: rtl/knapsack_search.sv
// Exhaustive 0-1 knapsack search: walks every selection, summing one item per cycle,
// and keeps the highest-value selection meeting the value/weight thresholds.
module knapsack_search #(
    parameter int N_ITEMS = 5,
    parameter int VW      = 16
) (
    input logic              clk,
    input logic              rst,
    knapsack_search_if.slave bus
);
    localparam int IW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam int AW = VW + 3;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [VW-1:0]      r_value  [N_ITEMS];
    logic [VW-1:0]      r_weight [N_ITEMS];
    logic [VW-1:0]      r_min, r_max;
    logic [IW-1:0]      r_k;
    logic [N_ITEMS-1:0] r_cand;
    logic [AW-1:0]      r_acc_v, r_acc_w;
    logic               r_found;
    logic [N_ITEMS-1:0] r_best_sel;
    logic [AW-1:0]      r_best_v, r_best_w;

    logic               w_start, w_last_item, w_last_cand, w_qualify, w_better;
    logic [AW-1:0]      w_sum_v, w_sum_w;

    assign w_start     = bus.i_start && (r_state != S_EVAL);
    assign w_last_item = (r_k == IW'(N_ITEMS - 1));
    assign w_last_cand = &r_cand;
    assign w_sum_v     = r_acc_v + (r_cand[r_k] ? AW'(r_value[r_k])  : '0);
    assign w_sum_w     = r_acc_w + (r_cand[r_k] ? AW'(r_weight[r_k]) : '0);
    assign w_qualify   = (w_sum_v >= AW'(r_min)) && (w_sum_w <= AW'(r_max));
    // Strict compare: on a tie the earlier (lower) selection stays best.
    assign w_better    = w_qualify && (!r_found || (w_sum_v > r_best_v));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: always_comb assigns every output a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_EVAL;
            S_EVAL:  if (w_last_item && w_last_cand) w_next = S_DONE;
            S_DONE:  w_next = w_start ? S_EVAL : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the item table is a small register file, so it can and must be cleared on reset.
            for (int i = 0; i < N_ITEMS; i++) begin
                r_value[i]  <= '0;
                r_weight[i] <= '0;
            end
            r_min      <= '0;
            r_max      <= '0;
            r_k        <= '0;
            r_cand     <= '0;
            r_acc_v    <= '0;
            r_acc_w    <= '0;
            r_found    <= 1'b0;
            r_best_sel <= '0;
            r_best_v   <= '0;
            r_best_w   <= '0;
        end else begin
            if (bus.i_cfg_we && (r_state != S_EVAL) && (int'(bus.i_cfg_idx) < N_ITEMS)) begin
                r_value[bus.i_cfg_idx]  <= bus.i_cfg_value;
                r_weight[bus.i_cfg_idx] <= bus.i_cfg_weight;
            end
            if (w_start) begin
                r_min      <= bus.i_min_value;
                r_max      <= bus.i_max_weight;
                r_k        <= '0;
                r_cand     <= '0;
                r_acc_v    <= '0;
                r_acc_w    <= '0;
                r_found    <= 1'b0;
                r_best_sel <= '0;
                r_best_v   <= '0;
                r_best_w   <= '0;
            end else if (r_state == S_EVAL) begin
                if (w_last_item) begin
                    if (w_better) begin
                        r_found    <= 1'b1;
                        r_best_sel <= r_cand;
                        r_best_v   <= w_sum_v;
                        r_best_w   <= w_sum_w;
                    end
                    r_acc_v <= '0;
                    r_acc_w <= '0;
                    r_k     <= '0;
                    // Wraps to zero after the last candidate, leaving cand_sel at 0 outside EVAL.
                    r_cand  <= r_cand + N_ITEMS'(1);
                end else begin
                    r_acc_v <= w_sum_v;
                    r_acc_w <= w_sum_w;
                    r_k     <= r_k + IW'(1);
                end
            end
        end
    end

    assign bus.o_busy        = (r_state == S_EVAL);
    assign bus.o_done        = (r_state == S_DONE);
    assign bus.o_found       = r_found;
    assign bus.o_best_sel    = r_best_sel;
    assign bus.o_best_value  = r_best_v;
    assign bus.o_best_weight = r_best_w;
    assign bus.o_cand_sel    = r_cand;
endmodule
